// File: rtl/write_dec_reg.sv
// Write-side port decoder: turns a processor write strobe into a one-shot pulse
// per port, captures data into eight holding registers, and tracks new-data/overrun flags.
module write_dec_reg #(
   parameter int DW = 8,
   parameter int AW = 3
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    EN,
   input  logic                    w_strobe,
   input  logic [AW-1:0]           S,
   input  logic [DW-1:0]           din,
   input  logic [(2**AW)-1:0]      read,
   output logic [(2**AW)*DW-1:0]   q,
   output logic [(2**AW)-1:0]      write,
   output logic [(2**AW)-1:0]      updated,
   output logic [(2**AW)-1:0]      overrun
);

   localparam int NREG = 2**AW;

   typedef enum logic {IDLE = 1'b0, HOLD = 1'b1} state_t;

   state_t            state_q, state_d;
   logic              accept;
   logic [NREG-1:0]   wr_hit;
   logic [NREG-1:0]   write_q, write_d;
   logic [NREG-1:0]   updated_q, updated_d;
   logic [NREG-1:0]   overrun_q, overrun_d;
   logic [DW-1:0]     data_q [NREG];

   // A write is taken only on the IDLE->HOLD transition, so a held strobe counts once.
   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
      case (state_q)
         IDLE: begin
            if (!EN && w_strobe) begin
               accept  = 1'b1;
               state_d = HOLD;
            end
         end
         HOLD: begin
            if (!w_strobe) state_d = IDLE;
         end
         default: state_d = HOLD;
      endcase
   end

   assign wr_hit  = accept ? (NREG'(1) << S) : '0;
   assign write_d = wr_hit;

   // A read in the same cycle as a write consumed the old value, so no overrun.
   always_comb begin
      updated_d = updated_q;
      overrun_d = overrun_q;
      for (int i = 0; i < NREG; i++) begin
         if (wr_hit[i]) begin
            updated_d[i] = 1'b1;
            if (!read[i] && updated_q[i]) overrun_d[i] = 1'b1;
         end else if (read[i]) begin
            updated_d[i] = 1'b0;
            overrun_d[i] = 1'b0;
         end
      end
   end

   // Reset parks the FSM in HOLD so a strobe already high at release is ignored.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= HOLD;
         write_q   <= '0;
         updated_q <= '0;
         overrun_q <= '0;
         for (int i = 0; i < NREG; i++) data_q[i] <= '0;
      end else begin
         state_q   <= state_d;
         write_q   <= write_d;
         updated_q <= updated_d;
         overrun_q <= overrun_d;
         for (int i = 0; i < NREG; i++) begin
            if (wr_hit[i]) data_q[i] <= din;
         end
      end
   end

   always_comb begin
      q = '0;
      for (int i = 0; i < NREG; i++) q[i*DW +: DW] = data_q[i];
   end

   assign write   = write_q;
   assign updated = updated_q;
   assign overrun = overrun_q;

endmodule

// File: tb/tb_write_dec_reg.sv
// Directed bench for write_dec_reg: hand-computed expectations for pulse timing,
// data capture, flag behaviour and reset interaction.
module tb_write_dec_reg;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        EN;
   logic        w_strobe;
   logic [2:0]  S;
   logic [7:0]  din;
   logic [7:0]  read;
   logic [63:0] q;
   logic [7:0]  write;
   logic [7:0]  updated;
   logic [7:0]  overrun;

   int n_chk  = 0;
   int n_pass = 0;

   write_dec_reg #(.DW(8), .AW(3)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .EN       (EN),
      .w_strobe (w_strobe),
      .S        (S),
      .din      (din),
      .read     (read),
      .q        (q),
      .write    (write),
      .updated  (updated),
      .overrun  (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [7:0] port(input int p);
      return q[8*p +: 8];
   endfunction

   int n5, n6, nw;

   initial begin
      reset_n = 1'b0; EN = 1'b1; w_strobe = 1'b0; S = '0; din = '0; read = '0;
      tick(); tick();
      chk("rst_q", q, 64'h0);
      chk("rst_write", write, 8'h00);
      chk("rst_updated", updated, 8'h00);
      chk("rst_overrun", overrun, 8'h00);
      reset_n = 1'b1;
      tick();

      // single short write to port 2
      EN = 1'b0; w_strobe = 1'b1; S = 3'd2; din = 8'hA5;
      tick();
      chk("t1_write", write, 8'h04);
      chk("t1_q2", port(2), 8'hA5);
      chk("t1_updated", updated, 8'h04);
      chk("t1_overrun", overrun, 8'h00);
      w_strobe = 1'b0;
      tick();
      chk("t1_write_off", write, 8'h00);

      // long strobe to port 5, select changes mid-hold
      n5 = 0; n6 = 0;
      w_strobe = 1'b1; S = 3'd5; din = 8'h3C;
      for (int c = 0; c < 5; c++) begin
         if (c == 2) begin S = 3'd6; din = 8'h77; end
         tick();
         if (write[5]) n5++;
         if (write[6]) n6++;
      end
      w_strobe = 1'b0;
      tick();
      chk("t2_pulses5", n5, 1);
      chk("t2_pulses6", n6, 0);
      chk("t2_q5", port(5), 8'h3C);
      chk("t2_q6", port(6), 8'h00);
      chk("t2_updated", updated, 8'h24);

      // disabled block ignores strobe
      EN = 1'b1; w_strobe = 1'b1; S = 3'd0; din = 8'hFF;
      tick();
      chk("t3_write", write, 8'h00);
      w_strobe = 1'b0;
      tick();
      chk("t3_q0", port(0), 8'h00);
      chk("t3_updated", updated, 8'h24);
      EN = 1'b0;

      // double write to port 1 sets overrun, read clears both flags
      w_strobe = 1'b1; S = 3'd1; din = 8'h11;
      tick();
      w_strobe = 1'b0;
      tick();
      chk("t4_first_q1", port(1), 8'h11);
      chk("t4_first_ovr", overrun, 8'h00);
      w_strobe = 1'b1; din = 8'h22;
      tick();
      chk("t4_write2", write, 8'h02);
      w_strobe = 1'b0;
      tick();
      chk("t4_q1", port(1), 8'h22);
      chk("t4_updated", updated, 8'h26);
      chk("t4_overrun", overrun, 8'h02);
      read = 8'h02;
      tick();
      read = 8'h00;
      chk("t4_rd_updated", updated, 8'h24);
      chk("t4_rd_overrun", overrun, 8'h00);

      // rewrite of port 7 with simultaneous read: no overrun
      w_strobe = 1'b1; S = 3'd7; din = 8'h71;
      tick();
      w_strobe = 1'b0;
      tick();
      chk("t5_upd_pre", updated, 8'hA4);
      w_strobe = 1'b1; din = 8'h72; read = 8'h80;
      tick();
      w_strobe = 1'b0; read = 8'h00;
      chk("t5_updated", updated, 8'hA4);
      chk("t5_overrun", overrun, 8'h00);
      chk("t5_q7", port(7), 8'h72);
      tick();

      // reset while holding strobe; no write until strobe falls and rises again
      w_strobe = 1'b1; S = 3'd3; din = 8'h33;
      tick();
      chk("t6_pre_write", write, 8'h08);
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      chk("t6_rst_write", write, 8'h00);
      chk("t6_rst_q", q, 64'h0);
      chk("t6_rst_updated", updated, 8'h00);
      nw = 0;
      for (int c = 0; c < 3; c++) begin
         tick();
         if (write != 8'h00) nw++;
      end
      w_strobe = 1'b0;
      tick();
      if (write != 8'h00) nw++;
      chk("t6_no_write", nw, 0);
      w_strobe = 1'b1; S = 3'd4; din = 8'h5A;
      tick();
      chk("t6_write4", write, 8'h10);
      chk("t6_q4", port(4), 8'h5A);
      w_strobe = 1'b0;
      tick();
      chk("t6_write_off", write, 8'h00);
      chk("t6_updated", updated, 8'h10);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
